// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed load/store unit in front of a word-organised data
// memory. Requests are captured on a valid/ready handshake, turned into one or
// two word accesses (two when the access straddles a word boundary), and
// completed with a single-cycle response carrying aligned, extended load data.
module dmem_lsu #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [XLEN-1:0]          i_req_addr,
    input  logic [1:0]               i_req_size,
    input  logic                     i_req_unsigned,
    input  logic [XLEN-1:0]          i_req_wdata,
    output logic                     o_rsp_valid,
    output logic [XLEN-1:0]          o_rsp_rdata,
    output logic                     o_rsp_err,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN-1:0]          o_dmem_data,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic                     o_dmem_wr_en,
    input  logic [XLEN-1:0]          i_dmem_data
);

    localparam int WIDX = DMEM_ADDR_BIT - 2;
    localparam logic [WIDX-1:0] LAST_WORD = {WIDX{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    // Number of bytes moved for a size code; the illegal code maps to 0.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] nb;
        case (size)
            2'b00:   nb = 3'd1;
            2'b01:   nb = 3'd2;
            2'b10:   nb = 3'd4;
            default: nb = 3'd0;
        endcase
        return nb;
    endfunction

    // Byte-lane write mask for either the first (hi=0) or second (hi=1) word.
    function automatic logic [3:0] store_lanes(input logic [1:0] size,
                                               input logic [1:0] off,
                                               input logic       hi);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'b0000_0001;
            2'b01:   m = 8'b0000_0011;
            2'b10:   m = 8'b0000_1111;
            default: m = 8'b0000_0000;
        endcase
        m = m << off;
        return hi ? m[7:4] : m[3:0];
    endfunction

    // Store data moved into its byte lanes; bytes beyond the access size are
    // cleared so the memory bus never carries stale upper store bytes.
    function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        hi);
        logic [63:0] wide;
        case (size)
            2'b00:   wide = {56'd0, wdata[7:0]};
            2'b01:   wide = {48'd0, wdata[15:0]};
            default: wide = {32'd0, wdata};
        endcase
        wide = wide << {off, 3'b000};
        return hi ? wide[63:32] : wide[31:0];
    endfunction

    // Extracts the addressed bytes from the {high,low} word pair and extends
    // them; word loads are never extended so the unsigned flag is moot there.
    function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] win;
        logic [31:0] res;
        win = 32'(pair >> {off, 3'b000});
        case (size)
            2'b00:   res = uns ? {24'd0, win[7:0]}  : {{24{win[7]}}, win[7:0]};
            2'b01:   res = uns ? {16'd0, win[15:0]} : {{16{win[15]}}, win[15:0]};
            default: res = win;
        endcase
        return res;
    endfunction

    // Request fields captured at the handshake
    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [WIDX-1:0]   w0_q, w0_d;
    logic              split_q, split_d;
    logic [XLEN-1:0]   low_q, low_d;

    // Registered outputs
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [WIDX-1:0]   dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]   dmem_data_q, dmem_data_d;
    logic [3:0]        byte_sel_q, byte_sel_d;
    logic              wr_en_q, wr_en_d;

    // Decode of the request currently presented on the input port
    logic [2:0]        req_nbytes_s;
    logic              req_split_s;
    logic              req_oob_s;
    logic              req_err_s;
    logic [WIDX-1:0]   req_w0_s;

    // Classify the incoming request: split, out of range, or illegal.
    always_comb begin
        req_nbytes_s = size_to_nbytes(i_req_size);
        req_w0_s     = i_req_addr[DMEM_ADDR_BIT-1:2];
        req_split_s  = ({2'b00, i_req_addr[1:0]} + {1'b0, req_nbytes_s}) > 4'd4;
        req_oob_s    = |i_req_addr[XLEN-1:DMEM_ADDR_BIT];
        // A split access from the last word would need to wrap; reject it.
        req_err_s    = (i_req_size == 2'b11) || req_oob_s ||
                       (req_split_s && (req_w0_s == LAST_WORD));
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        w0_d        = w0_q;
        split_d     = split_q;
        low_d       = low_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        dmem_addr_d = dmem_addr_q;
        dmem_data_d = dmem_data_q;
        byte_sel_d  = 4'b0000;
        wr_en_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    off_d   = i_req_addr[1:0];
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    wdata_d = i_req_wdata;
                    w0_d    = req_w0_s;
                    split_d = req_split_s;
                    if (req_err_s) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        // Outputs are registered, so the first access is
                        // prepared here from the live request fields.
                        state_d     = ST_ACC0;
                        dmem_addr_d = req_w0_s;
                        if (i_req_we) begin
                            wr_en_d     = 1'b1;
                            byte_sel_d  = store_lanes(i_req_size, i_req_addr[1:0], 1'b0);
                            dmem_data_d = store_data(i_req_wdata, i_req_size,
                                                     i_req_addr[1:0], 1'b0);
                        end else begin
                            wr_en_d = 1'b0;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (!we_q) begin
                    low_d = i_dmem_data;
                end else begin
                    low_d = low_q;
                end
                if (split_q) begin
                    state_d     = ST_ACC1;
                    dmem_addr_d = w0_q + WIDX'(1);
                    if (we_q) begin
                        wr_en_d     = 1'b1;
                        byte_sel_d  = store_lanes(size_q, off_q, 1'b1);
                        dmem_data_d = store_data(wdata_q, size_q, off_q, 1'b1);
                    end else begin
                        wr_en_d = 1'b0;
                    end
                end else begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    if (we_q) begin
                        rsp_rdata_d = '0;
                    end else begin
                        rsp_rdata_d = load_extend({32'd0, i_dmem_data}, off_q, size_q, uns_q);
                    end
                end
            end
            ST_ACC1: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                if (we_q) begin
                    rsp_rdata_d = '0;
                end else begin
                    rsp_rdata_d = load_extend({i_dmem_data, low_q}, off_q, size_q, uns_q);
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            w0_q        <= '0;
            split_q     <= 1'b0;
            low_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            dmem_addr_q <= '0;
            dmem_data_q <= '0;
            byte_sel_q  <= 4'b0000;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            w0_q        <= w0_d;
            split_q     <= split_d;
            low_q       <= low_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_data_q <= dmem_data_d;
            byte_sel_q  <= byte_sel_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign o_req_ready     = (state_q == ST_IDLE);
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_rdata     = rsp_rdata_q;
    assign o_rsp_err       = rsp_err_q;
    assign o_dmem_addr     = dmem_addr_q;
    assign o_dmem_data     = dmem_data_q;
    assign o_dmem_byte_sel = byte_sel_q;
    // A reset arriving during an access must not let that in-flight write
    // commit at the same edge, so the enable is qualified by the reset input.
    assign o_dmem_wr_en    = wr_en_q & i_rstn;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized
// requests compared against a byte-array reference memory model.
module tb_dmem_lsu;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [7:0]  o_dmem_addr;
    logic [31:0] o_dmem_data;
    logic [3:0]  o_dmem_byte_sel;
    logic        o_dmem_wr_en;
    logic [31:0] i_dmem_data;

    dmem_lsu #(.XLEN(32), .DMEM_ADDR_BIT(10)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_dmem_addr(o_dmem_addr), .o_dmem_data(o_dmem_data),
        .o_dmem_byte_sel(o_dmem_byte_sel), .o_dmem_wr_en(o_dmem_wr_en),
        .i_dmem_data(i_dmem_data)
    );

    always #5 i_clk = ~i_clk;

    // Word memory behind the LSU: combinational read, byte-masked write.
    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] wr_word;

    assign i_dmem_data = mem[o_dmem_addr];

    always @(posedge i_clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (o_dmem_wr_en) begin
            wr_word = mem[o_dmem_addr];
            for (int b = 0; b < 4; b++)
                if (o_dmem_byte_sel[b]) wr_word[8*b +: 8] = o_dmem_data[8*b +: 8];
            mem[o_dmem_addr] <= wr_word;
        end
    end

    // Reference byte-addressed memory
    logic [7:0] ref_mem [0:1023];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observations from the last request
    int          lat;
    int          wr_cnt;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  a0, a1;
    logic [3:0]  s0, s1;
    logic [31:0] d0, d1;
    logic        we0, we1;

    // Issue one request (called at #1 after a rising edge, DUT idle) and
    // observe every cycle until the response, bounded to 6 cycles.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
        int   k;
        logic done;
        check_val("ready_idle", {31'd0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr;
        i_req_size = size; i_req_unsigned = uns; i_req_wdata = wdata;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_req_we = 1'($urandom); i_req_addr = $urandom; i_req_size = 2'($urandom);
        i_req_unsigned = 1'($urandom); i_req_wdata = $urandom;
        k = 0; done = 1'b0; wr_cnt = 0; lat = 99; rsp_data = 32'd0; rsp_err = 1'b0;
        while (!done && k < 6) begin
            if (k == 0) begin a0 = o_dmem_addr; s0 = o_dmem_byte_sel; d0 = o_dmem_data; we0 = o_dmem_wr_en; end
            if (k == 1) begin a1 = o_dmem_addr; s1 = o_dmem_byte_sel; d1 = o_dmem_data; we1 = o_dmem_wr_en; end
            if (o_dmem_wr_en) wr_cnt++;
            if (o_rsp_valid) begin
                done = 1'b1; lat = k + 1; rsp_data = o_rsp_rdata; rsp_err = o_rsp_err;
            end else begin
                @(posedge i_clk); #1;
                k++;
            end
        end
        @(posedge i_clk); #1;
    endtask

    // Reference model: derives expected outcome from the byte-level rules.
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output logic e_err, output int e_lat, output int e_wr,
                         output logic [31:0] e_rdata);
        int nb, off;
        logic split;
        logic [31:0] val;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        off = int'(addr % 4);
        split = (off + nb) > 4;
        e_err = (size == 2'd3) || (addr >= 32'd1024) || (split && (addr >> 2) == 32'd255);
        e_rdata = 32'd0;
        if (e_err) begin
            e_lat = 1; e_wr = 0;
        end else begin
            e_lat = split ? 3 : 2;
            if (we) begin
                e_wr = split ? 2 : 1;
                for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                e_wr = 0;
                val = 32'd0;
                for (int i = 0; i < nb; i++) val = val | ({24'd0, ref_mem[addr + i]} << (8*i));
                if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
                e_rdata = val;
            end
        end
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
        logic e_err; int e_lat; int e_wr; logic [31:0] e_rdata;
        do_req(we, addr, size, uns, wdata);
        model(we, addr, size, uns, wdata, e_err, e_lat, e_wr, e_rdata);
        check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
        check_val("latency", 32'(lat), 32'(e_lat));
        check_val("rsp_rdata", rsp_data, e_rdata);
        check_val("wr_cycles", 32'(wr_cnt), 32'(e_wr));
    endtask

    logic        r_we, r_uns;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    int          sel;

    initial begin
        i_rstn = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = 32'd0;
        i_req_size = 2'd0; i_req_unsigned = 1'b0; i_req_wdata = 32'd0;
        pl_en = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        check_val("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check_val("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        check_val("rst_rdata", o_rsp_rdata, 32'd0);
        check_val("rst_wr_en", {31'd0, o_dmem_wr_en}, 32'd0);
        check_val("rst_byte_sel", {28'd0, o_dmem_byte_sel}, 32'd0);
        check_val("rst_addr", {24'd0, o_dmem_addr}, 32'd0);
        check_val("rst_data", o_dmem_data, 32'd0);

        // Preload memory with random contents while held in reset
        for (int w = 0; w < 256; w++) begin
            pl_en = 1'b1; pl_addr = 8'(w); pl_data = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = pl_data[8*b +: 8];
            @(posedge i_clk); #1;
        end
        pl_en = 1'b0;
        i_rstn = 1'b1;
        @(posedge i_clk); #1;
        check_val("ready_after_rst", {31'd0, o_req_ready}, 32'd1);

        // Aligned word store/load
        run_req(1'b1, 32'h010, 2'd2, 1'b0, 32'hDEADBEEF);
        check_val("sw_acc0_addr", {24'd0, a0}, 32'd4);
        check_val("sw_acc0_sel", {28'd0, s0}, 32'hF);
        check_val("sw_acc0_we", {31'd0, we0}, 32'd1);
        run_req(1'b0, 32'h010, 2'd2, 1'b0, 32'd0);
        check_val("lw_dir", rsp_data, 32'hDEADBEEF);

        // Byte store and sign/zero-extended byte loads
        run_req(1'b1, 32'h013, 2'd0, 1'b0, 32'h0000_0080);
        check_val("sb_sel", {28'd0, s0}, 32'h8);
        check_val("sb_data", d0, 32'h8000_0000);
        run_req(1'b0, 32'h013, 2'd0, 1'b0, 32'd0);
        check_val("lb_dir", rsp_data, 32'hFFFF_FF80);
        run_req(1'b0, 32'h013, 2'd0, 1'b1, 32'd0);
        check_val("lbu_dir", rsp_data, 32'h0000_0080);

        // Split word store and load
        run_req(1'b1, 32'h022, 2'd2, 1'b0, 32'h11223344);
        check_val("ssw_a0", {24'd0, a0}, 32'd8);
        check_val("ssw_s0", {28'd0, s0}, 32'hC);
        check_val("ssw_d0", d0, 32'h3344_0000);
        check_val("ssw_a1", {24'd0, a1}, 32'd9);
        check_val("ssw_s1", {28'd0, s1}, 32'h3);
        check_val("ssw_d1", d1, 32'h0000_1122);
        run_req(1'b0, 32'h022, 2'd2, 1'b0, 32'd0);
        check_val("slw_dir", rsp_data, 32'h11223344);
        check_val("slw_lat", 32'(lat), 32'd3);

        // Split halfword loads
        run_req(1'b1, 32'h000, 2'd2, 1'b0, 32'h8000_0000);
        run_req(1'b1, 32'h004, 2'd2, 1'b0, 32'h0000_00FF);
        run_req(1'b0, 32'h003, 2'd1, 1'b0, 32'd0);
        check_val("lh_split", rsp_data, 32'hFFFF_FF80);
        run_req(1'b0, 32'h003, 2'd1, 1'b1, 32'd0);
        check_val("lhu_split", rsp_data, 32'h0000_FF80);

        // Error requests
        run_req(1'b1, 32'h400, 2'd2, 1'b0, 32'hCAFEF00D);
        check_val("err_oob", {31'd0, rsp_err}, 32'd1);
        run_req(1'b1, 32'h3FF, 2'd1, 1'b0, 32'h0000_BEEF);
        check_val("err_lastword", {31'd0, rsp_err}, 32'd1);
        run_req(1'b1, 32'h040, 2'd3, 1'b0, 32'h1234_5678);
        check_val("err_size", {31'd0, rsp_err}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0)      r_addr = $urandom;
            else if (sel < 3)  r_addr = $urandom_range(1016, 1023);
            else if (sel < 6)  r_addr = $urandom_range(0, 31);
            else               r_addr = $urandom_range(0, 1023);
            sel = $urandom_range(0, 9);
            r_size  = (sel == 9) ? 2'd3 : 2'(sel % 3);
            r_we    = 1'($urandom);
            r_uns   = 1'($urandom);
            r_wdata = $urandom;
            run_req(r_we, r_addr, r_size, r_uns, r_wdata);
        end

        // Reset in the middle of a split store: word 40 keeps its new bytes,
        // word 41 is untouched, no response appears.
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h0A2;
        i_req_size = 2'd2; i_req_unsigned = 1'b0; i_req_wdata = 32'hAABBCCDD;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        check_val("rst_acc0_addr", {24'd0, o_dmem_addr}, 32'd40);
        @(posedge i_clk); #1;
        check_val("rst_acc1_addr", {24'd0, o_dmem_addr}, 32'd41);
        i_rstn = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        ref_mem[32'h0A2] = 8'hDD;
        ref_mem[32'h0A3] = 8'hCC;
        check_val("midrst_ready", {31'd0, o_req_ready}, 32'd1);
        check_val("midrst_rsp", {31'd0, o_rsp_valid}, 32'd0);
        check_val("midrst_wr_en", {31'd0, o_dmem_wr_en}, 32'd0);
        check_val("midrst_sel", {28'd0, o_dmem_byte_sel}, 32'd0);
        check_val("midrst_addr", {24'd0, o_dmem_addr}, 32'd0);
        check_val("midrst_data", o_dmem_data, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            check_val("midrst_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        end
        run_req(1'b0, 32'h0A0, 2'd2, 1'b0, 32'd0);

        // Whole-memory comparison against the reference
        for (int w = 0; w < 256; w++)
            check_val("mem_sweep", mem[w],
                      {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the word-organised data memory.
- Accepts byte-addressed load/store requests from the core over a valid/ready handshake.
- Converts each request into word-address, byte-select and write-enable accesses on the data memory port, then returns aligned, sign- or zero-extended load data.
- Splits any access that crosses a 32-bit word boundary into two sequential word accesses.

Parameters:
- XLEN, 32, data width; fixed at 32.
- DMEM_ADDR_BIT, 10, byte-address width of data memory; word index is DMEM_ADDR_BIT-2 bits.

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rstn  in  1  synchronous active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1=store, 0=load
- i_req_addr  in  XLEN  byte address
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  zero-extend load (lbu/lhu)
- i_req_wdata  in  XLEN  store data, right-justified
- o_rsp_valid  out  1  one-cycle pulse; completion of every accepted request
- o_rsp_rdata  out  XLEN  load result; 0 for stores and errors
- o_rsp_err  out  1  request rejected; no memory write performed
- o_dmem_addr  out  DMEM_ADDR_BIT-2  word index to memory
- o_dmem_data  out  XLEN  write data to memory
- o_dmem_byte_sel  out  XLEN/8  byte lane write mask
- o_dmem_wr_en  out  1  memory write enable
- i_dmem_data  in  XLEN  combinational read data from memory at o_dmem_addr

Behaviour:
- Reset (i_rstn low at a clock edge):
  - State goes to IDLE.
  - o_rsp_valid, o_rsp_err, o_dmem_wr_en, o_dmem_byte_sel, o_dmem_addr, o_dmem_data, o_rsp_rdata all 0.
  - o_req_ready goes to 1 on the first cycle after reset deasserts.
- Request capture:
  - Handshake fires when i_req_valid && o_req_ready. All request fields are registered at that edge.
  - Fields are ignored when ready is low. No request queuing.
- Derived fields:
  - off = addr[1:0]; nbytes = 1/2/4.
  - w0 = addr[DMEM_ADDR_BIT-1:2]; w1 = w0+1.
  - split = (off+nbytes > 4).
- Error conditions: size==11, or any addr bit at or above DMEM_ADDR_BIT set, or split && w0 == last word.
  - Error requests skip all memory access and go IDLE -> RSP.
  - Response: err=1, rdata=0. No wrap-around is ever performed.
- States:
  - IDLE: ready=1. On fire, go to ACC0, or to RSP if error.
  - ACC0: o_dmem_addr=w0.
    - Store: wr_en=1, byte_sel=mask[3:0], data=shifted[31:0].
    - Load: capture i_dmem_data into low buffer.
    - Go to ACC1 if split, else RSP.
  - ACC1: o_dmem_addr=w1.
    - Store: wr_en=1, byte_sel=mask[7:4], data=shifted[63:32].
    - Load: capture i_dmem_data into high buffer.
    - Go to RSP.
  - RSP: o_rsp_valid=1 for exactly one cycle with rdata/err valid. Go to IDLE.
- Store lane rules:
  - mask = ((1<<nbytes)-1) << off, 8 bits.
  - shifted = {32'b0, wdata} << (8*off), 64 bits.
  - Only the low nbytes of wdata are used.
- Load rules:
  - window = {high, low} >> (8*off).
  - Take low nbytes, sign-extend from bit 8*nbytes-1 unless i_req_unsigned.
  - Word loads ignore i_req_unsigned.
- Outside ACC0/ACC1: wr_en=0, byte_sel=0; o_dmem_addr holds its last value.
- Latency from accepting edge N:
  - Aligned: rsp_valid during cycle N+2.
  - Split: rsp_valid during cycle N+3.
  - Error: rsp_valid during cycle N+1.
  - Next request can be accepted in the cycle after RSP.
- Reset mid-operation: abort immediately to IDLE with no response. A split store already past ACC0 leaves word w0 written (no rollback).
- Memory read is combinational, so load capture uses i_dmem_data in the same cycle as o_dmem_addr.

Test Plan:
- Aligned word: sw 0xDEADBEEF to 0x010, then lw 0x010.
  - sw: ACC0 wr_en=1, addr=4, byte_sel=1111.
  - lw: rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
- Sub-word sign: store byte 0x80 to 0x013.
  - ACC0: byte_sel=1000, data=0x80000000.
  - lb 0x013 -> 0xFFFFFF80; lbu 0x013 -> 0x00000080.
- Split word: sw 0x11223344 to 0x022.
  - ACC0: addr=8, byte_sel=1100, data=0x33440000.
  - ACC1: addr=9, byte_sel=0011, data=0x00001122.
  - Then lw 0x022 -> 0x11223344, rsp 3 cycles after accept.
- Split half: mem word 0 = 0x80000000, word 1 = 0x000000FF; lh 0x003 -> 0xFFFFFF80 (bytes 0x80, 0xFF -> 0xFF80 sign-extended); lhu 0x003 -> 0x0000FF80.
- Errors, each giving err=1 one cycle after accept with no wr_en:
  - sw to 0x400.
  - sh to 0x3FF (crosses last word).
  - size=11.
- Reset: assert i_rstn=0 during ACC1 of a split store.
  - Next cycle: IDLE, ready=1, no rsp_valid, all dmem outputs 0.
  - Word w0 holds the new bytes; word w1 is unchanged.
